// File: rtl/fifo_rd_drain_pkg.sv
// rtl/fifo_rd_drain_pkg.sv - shared defaults and helpers for the FIFO read-side drain controller
package fifo_rd_drain_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF  = 16;
  localparam int BUF_DEPTH      = 2;

  typedef logic [1:0] buf_cnt_t;

  // Projected occupancy after this cycle; 3 bits so it can never wrap.
  function automatic logic [2:0] occ_next(input buf_cnt_t cnt, input logic infl, input logic pop);
    return {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// rtl/fifo_rd_skid_buf.sv - two-entry ordered buffer absorbing the FIFO read latency
module fifo_rd_skid_buf
  import fifo_rd_drain_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output buf_cnt_t         o_count
);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic             r_head;
  logic             r_tail;
  buf_cnt_t         r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= ~r_tail;
      if (i_pop)  r_head <= ~r_head;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // Storage carries no reset; contents are only observed while r_count is non-zero.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_wdata;
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - drains a synchronous FIFO into a valid/ready stream with pop counting
module fifo_rd_drain
  import fifo_rd_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  drain_en,
  input  logic                  empty,
  input  logic                  underflow,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  err_underflow
);

  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_pop_count;
  logic                 r_err_underflow;
  buf_cnt_t             w_count;
  logic                 w_pop;
  logic [2:0]           w_occ;

  fifo_rd_skid_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_wdata (data_out),
    .i_pop   (w_pop),
    .o_rdata (m_data),
    .o_count (w_count)
  );

  assign m_valid = (w_count != 2'd0);
  assign w_pop   = m_valid && m_ready;

  // Counting the same-cycle pop lets a read issue into a slot that is just being vacated.
  always_comb begin
    w_occ = occ_next(w_count, r_inflight, w_pop);
    rd_en = rst_n && drain_en && !empty && (w_occ < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight      <= 1'b0;
      r_pop_count     <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_inflight <= rd_en;
      if (w_pop) r_pop_count <= r_pop_count + CNT_WIDTH'(1);
      if (underflow) r_err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(r_inflight && (w_count == 2'd2) && !w_pop));
    end
  end

  assign pop_count     = r_pop_count;
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - directed self-checking bench for fifo_rd_drain
module tb_fifo_rd_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drain_en = 1'b0;
  logic        empty;
  logic        underflow = 1'b0;
  logic [15:0] data_out = 16'h0000;
  logic        rd_en;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] pop_count;
  logic        err_underflow;

  logic        rd_en_w4;
  logic [15:0] m_data_w4;
  logic        m_valid_w4;
  logic [3:0]  pop_count_w4;
  logic        err_underflow_w4;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] fmem [0:255];
  int wr_cnt = 0;
  int rd_ptr = 0;

  always #5 clk = ~clk;

  fifo_rd_drain #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .drain_en      (drain_en),
    .empty         (empty),
    .underflow     (underflow),
    .data_out      (data_out),
    .rd_en         (rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .pop_count     (pop_count),
    .err_underflow (err_underflow)
  );

  fifo_rd_drain #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut_w4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .drain_en      (drain_en),
    .empty         (empty),
    .underflow     (underflow),
    .data_out      (data_out),
    .rd_en         (rd_en_w4),
    .m_data        (m_data_w4),
    .m_valid       (m_valid_w4),
    .m_ready       (m_ready),
    .pop_count     (pop_count_w4),
    .err_underflow (err_underflow_w4)
  );

  // Synchronous FIFO model with registered read data, cleared by the shared reset.
  assign empty = (rd_ptr >= wr_cnt);

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= wr_cnt;
    end else if (rd_en) begin
      data_out <= fmem[rd_ptr[7:0]];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fmem[wr_cnt[7:0]] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    drain_en = 1'b1;
    rst_n    = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      nvec++; if (rd_en !== 1'b0) begin nerr++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
      nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
      nvec++; if (pop_count !== 16'd0) begin nerr++; $display("FAIL reset_pop_count: got %0d want 0", pop_count); end
      nvec++; if (err_underflow !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    end
    rst_n = 1'b1;
    step();
    nvec++; if (rd_en !== 1'b0) begin nerr++; $display("FAIL idle_rd_en: got %b want 0", rd_en); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL idle_m_valid: got %b want 0", m_valid); end
  endtask

  task automatic test_single;
    drain_en = 1'b1;
    m_ready  = 1'b1;
    apply_reset();
    push(16'hA5A5);
    #1;
    nvec++; if (rd_en !== 1'b1) begin nerr++; $display("FAIL single_rd_en_n: got %b want 1", rd_en); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL single_valid_n: got %b want 0", m_valid); end
    step();
    nvec++; if (rd_en !== 1'b0) begin nerr++; $display("FAIL single_rd_en_n1: got %b want 0", rd_en); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL single_valid_n1: got %b want 0", m_valid); end
    step();
    nvec++; if (m_valid !== 1'b1) begin nerr++; $display("FAIL single_valid_n2: got %b want 1", m_valid); end
    nvec++; if (m_data !== 16'hA5A5) begin nerr++; $display("FAIL single_data: got %h want a5a5", m_data); end
    step();
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL single_valid_n3: got %b want 0", m_valid); end
    nvec++; if (pop_count !== 16'd1) begin nerr++; $display("FAIL single_pop_count: got %0d want 1", pop_count); end
  endtask

  task automatic test_stream;
    drain_en = 1'b1;
    m_ready  = 1'b1;
    apply_reset();
    for (int i = 1; i <= 8; i++) push(16'(i));
    #1;
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL stream_valid_n: got %b want 0", m_valid); end
    step();
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL stream_valid_n1: got %b want 0", m_valid); end
    for (int i = 1; i <= 8; i++) begin
      step();
      nvec++;
      if (m_valid !== 1'b1 || m_data !== 16'(i)) begin
        nerr++; $display("FAIL stream_word%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, 16'(i));
      end
    end
    step();
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL stream_valid_end: got %b want 0", m_valid); end
    nvec++; if (pop_count !== 16'd8) begin nerr++; $display("FAIL stream_pop_count: got %0d want 8", pop_count); end
  endtask

  task automatic test_backpressure;
    int nrd;
    int n;
    logic [15:0] got [0:15];
    drain_en = 1'b1;
    m_ready  = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) push(16'h0010 + 16'(i));
    #1;
    nrd = 0;
    for (int c = 0; c < 6; c++) begin
      if (rd_en) nrd++;
      step();
    end
    nvec++; if (nrd !== 2) begin nerr++; $display("FAIL bp_reads: got %0d want 2", nrd); end
    nvec++; if (rd_en !== 1'b0) begin nerr++; $display("FAIL bp_rd_en_held: got %b want 0", rd_en); end
    nvec++; if (m_valid !== 1'b1 || m_data !== 16'h0010) begin
      nerr++; $display("FAIL bp_head: got valid=%b data=%h want valid=1 data=0010", m_valid, m_data);
    end
    m_ready = 1'b1;
    #1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_valid && n < 16) begin got[n] = m_data; n++; end
      step();
    end
    nvec++; if (n !== 4) begin nerr++; $display("FAIL bp_count: got %0d words want 4", n); end
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (k >= n || got[k] !== 16'h0010 + 16'(k)) begin
        nerr++; $display("FAIL bp_order%0d: got %h want %h", k, (k < n) ? got[k] : 16'hxxxx, 16'h0010 + 16'(k));
      end
    end
    nvec++; if (pop_count !== 16'd4) begin nerr++; $display("FAIL bp_pop_count: got %0d want 4", pop_count); end
  endtask

  task automatic test_holdoff_error;
    int nrd;
    int nv;
    logic [15:0] first;
    drain_en = 1'b1;
    m_ready  = 1'b1;
    apply_reset();
    for (int i = 0; i < 3; i++) push(16'h0050 + 16'(i));
    #1;
    nvec++; if (rd_en !== 1'b1) begin nerr++; $display("FAIL hold_rd_en_first: got %b want 1", rd_en); end
    step();
    drain_en = 1'b0;
    #1;
    nvec++; if (rd_en !== 1'b0) begin nerr++; $display("FAIL hold_rd_en_off: got %b want 0", rd_en); end
    nrd = 0; nv = 0; first = 16'h0000;
    for (int c = 0; c < 5; c++) begin
      if (rd_en) nrd++;
      if (m_valid) begin
        if (nv == 0) first = m_data;
        nv++;
      end
      step();
    end
    nvec++; if (nrd !== 0) begin nerr++; $display("FAIL hold_new_reads: got %0d want 0", nrd); end
    nvec++; if (nv !== 1) begin nerr++; $display("FAIL hold_delivered: got %0d want 1", nv); end
    nvec++; if (first !== 16'h0050) begin nerr++; $display("FAIL hold_data: got %h want 0050", first); end
    nvec++; if (pop_count !== 16'd1) begin nerr++; $display("FAIL hold_pop_count: got %0d want 1", pop_count); end
    nvec++; if (err_underflow !== 1'b0) begin nerr++; $display("FAIL err_pre: got %b want 0", err_underflow); end
    underflow = 1'b1;
    step();
    underflow = 1'b0;
    nvec++; if (err_underflow !== 1'b1) begin nerr++; $display("FAIL err_set: got %b want 1", err_underflow); end
    repeat (3) step();
    nvec++; if (err_underflow !== 1'b1) begin nerr++; $display("FAIL err_sticky: got %b want 1", err_underflow); end
    apply_reset();
    nvec++; if (err_underflow !== 1'b0) begin nerr++; $display("FAIL err_cleared: got %b want 0", err_underflow); end
    drain_en = 1'b1;
  endtask

  task automatic test_wrap_and_reset;
    drain_en = 1'b1;
    m_ready  = 1'b1;
    apply_reset();
    for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i));
    repeat (24) step();
    nvec++; if (pop_count !== 16'd17) begin nerr++; $display("FAIL wrap_pop16: got %0d want 17", pop_count); end
    nvec++; if (pop_count_w4 !== 4'd1) begin nerr++; $display("FAIL wrap_pop4: got %0d want 1", pop_count_w4); end
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(16'h0200 + 16'(i));
    repeat (4) step();
    nvec++; if (m_valid !== 1'b1 || m_data !== 16'h0200) begin
      nerr++; $display("FAIL mid_full_head: got valid=%b data=%h want valid=1 data=0200", m_valid, m_data);
    end
    nvec++; if (rd_en !== 1'b0) begin nerr++; $display("FAIL mid_full_rd_en: got %b want 0", rd_en); end
    rst_n = 1'b0;
    #1;
    nvec++; if (rd_en !== 1'b0) begin nerr++; $display("FAIL mid_rst_rd_en: got %b want 0", rd_en); end
    step();
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_valid: got %b want 0", m_valid); end
    nvec++; if (pop_count !== 16'd0) begin nerr++; $display("FAIL mid_rst_pop16: got %0d want 0", pop_count); end
    nvec++; if (pop_count_w4 !== 4'd0) begin nerr++; $display("FAIL mid_rst_pop4: got %0d want 0", pop_count_w4); end
    rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (3) step();
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL post_rst_valid: got %b want 0", m_valid); end
    nvec++; if (pop_count !== 16'd0) begin nerr++; $display("FAIL post_rst_pop: got %0d want 0", pop_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_holdoff_error();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
Read-side drain controller that sits directly downstream of the synchronous FIFO (FIFO_WIDTH 16, FIFO_DEPTH 8). It issues rd_en against the FIFO's empty flag and absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer. It presents popped words as a valid/ready stream to the next stage. It also counts popped words and flags any FIFO underflow as a protocol error.

Parameters:
FIFO_WIDTH, 16, data width; matches the FIFO data_out width.
CNT_WIDTH, 16, width of the pop counter.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  synchronous, active-low reset.
drain_en  in  1  1 = allowed to issue new reads; 0 = hold off new reads.
empty  in  1  FIFO empty flag.
underflow  in  1  FIFO underflow flag.
data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted rd_en.
rd_en  out  1  FIFO read request (combinational).
m_data  out  FIFO_WIDTH  stream data, taken from the buffer head.
m_valid  out  1  stream valid.
m_ready  in  1  stream ready from the downstream stage.
pop_count  out  CNT_WIDTH  number of words delivered on the stream (m_valid && m_ready); wraps modulo 2^CNT_WIDTH.
err_underflow  out  1  sticky; set when underflow is seen high.

Behaviour:
- Reset (rst_n low at a rising edge):
  - buf_count=0, inflight=0, m_valid=0, pop_count=0, err_underflow=0.
  - Buffer data is don't-care.
  - rd_en is forced 0 in every cycle in which rst_n is low.
- Internal state:
  - buf_count in 0..2.
  - inflight (1 bit) = rd_en was asserted in the previous cycle.
  - Two-entry buffer with head/tail pointers, or shift form; ordering is strict FIFO.
- Stream pop: pop = m_valid && m_ready, where m_valid = (buf_count != 0) and m_data = buffer head.
  - m_data is stable while m_valid=1 and m_ready=0.
- rd_en = rst_n && drain_en && !empty && ((buf_count + inflight - pop) < 2).
  - Computed with at least 3-bit arithmetic, no wrap.
  - Including pop gives full throughput: with m_ready held high and the FIFO non-empty, one word per cycle after a 2-cycle startup.
- Read latency: rd_en high in cycle N → data_out is captured into the buffer tail at the end of cycle N+1 (inflight=1 in N+1).
  - The earliest m_valid for that word is cycle N+2.
- Occupancy update each cycle: buf_count_next = buf_count + inflight − pop.
  - Capture and pop in the same cycle: count unchanged, head advances, tail written, order preserved.
  - Capture into a full buffer cannot occur by construction. An implementation assertion fires if inflight && buf_count==2 && !pop.
- drain_en low: no new rd_en is issued. An in-flight word is still captured. Buffered words still drain to the stream.
- pop_count increments by 1 on each pop and wraps from 2^CNT_WIDTH−1 to 0.
- err_underflow: set on any cycle with underflow=1. It stays set until reset and never drives further behaviour.
- Reset mid-operation: in-flight and buffered words are discarded. The next cycle after release behaves as from reset.
- The FIFO's reset is driven from the same rst_n, so both sides clear together.

Decomposition:
- Shared package (alongside shared_pkg): FIFO_WIDTH default, CNT_WIDTH default, constant BUF_DEPTH=2.
- One natural sub-module: fifo_rd_skid_buf. It is the 2-entry ordered buffer with push/pop/count; the parent keeps the rd_en logic, inflight, pop_count and the error flag.

Test Plan:
1. Reset then idle:
   - Stimulus: rst_n=0 for 2 cycles, empty=1.
   - Required: rd_en=0, m_valid=0, pop_count=0, err_underflow=0 throughout.
2. Single word:
   - Stimulus: empty=1→0 for one accepted read, data_out=16'hA5A5 in the following cycle, m_ready=1.
   - Required: rd_en high in cycle N; m_valid=1 with m_data=16'hA5A5 in N+2; pop_count=1.
3. Streaming:
   - Stimulus: 8 words 16'h0001..16'h0008 from a non-empty FIFO, m_ready=1.
   - Required: m_valid high for 8 consecutive cycles, in order; pop_count=8.
4. Backpressure:
   - Stimulus: m_ready=0 with the FIFO non-empty.
   - Required: exactly 2 reads issued, then rd_en=0; m_data held at the first word.
   - Then m_ready=1: words 1, 2, 3… emerge with no loss or duplication.
5. Hold-off and error:
   - Stimulus: drain_en drops while a read is in flight.
   - Required: that word is still delivered and no new rd_en is issued.
   - Stimulus: underflow pulsed for 1 cycle. Required: err_underflow=1 and stays 1 until rst_n=0.
6. Reset mid-stream and counter wrap:
   - Stimulus: rst_n=0 with buf_count=2.
   - Required: m_valid=0 next cycle and pop_count=0.
   - Stimulus: CNT_WIDTH=4 and 17 pops. Required: pop_count=1.
